hv_efuse_load_ctrl: RTL and testbench
=====================================

# hv_efuse_load_ctrl

Efuse load controller on the HV die. Consumes the load request raised by the HV control FSM, reads the efuse macro byte by byte with programmable setup, strobe and hold timing, and writes each byte into the register bank. It then checks the stored checksum and returns `o_efuse_load_done` and `o_efuse_vld` to the control FSM, which uses them for the WAIT_ST → NML_ST / TEST_ST decision.

## Interface
- `EFUSE_BYTE_NUM`, default 16: bytes read per load; the last byte is the checksum; minimum 2.
- `EFUSE_ADDR_W`, default 4: efuse and register byte address width; `2**EFUSE_ADDR_W >= EFUSE_BYTE_NUM`.
- `EFUSE_SETUP_CYC`, default 2: cycles with csb low and strobe low before the strobe; minimum 1.
- `EFUSE_STRB_CYC`, default 4: strobe high width in cycles; minimum 1.
- `EFUSE_HOLD_CYC`, default 1: cycles with strobe low after the strobe, before the next byte; minimum 1.
- `i_clk` input 1: clock.
- `i_rst_n` input 1: reset, asynchronous, active-low.
- `i_efuse_load_req` input 1: level load request from the control FSM; dropping it aborts the load or clears done.
- `o_efuse_csb` output 1: macro chip select, active-low.
- `o_efuse_strobe` output 1: macro read strobe.
- `o_efuse_addr` output EFUSE_ADDR_W: macro byte address.
- `i_efuse_dout` input 8: macro read data; valid while the strobe is high.
- `o_efuse_reg_wr_en` output 1: one-cycle register write pulse.
- `o_efuse_reg_addr` output EFUSE_ADDR_W: register write address, equal to the byte index.
- `o_efuse_reg_wdata` output 8: register write data.
- `o_efuse_load_done` output 1: load complete; held high while the request stays high.
- `o_efuse_vld` output 1: last completed load passed the checksum and was not blank.

## Operation
- FSM states: IDLE, SETUP, STRB, HOLD, CHK, DONE. `cyc_cnt` counts cycles within a phase. `byte_idx` counts bytes, 0 to EFUSE_BYTE_NUM-1.
- IDLE, on `i_efuse_load_req`=1:
  - go to SETUP;
  - clear `byte_idx`, the sum accumulator and `o_efuse_vld`.
- SETUP: lasts EFUSE_SETUP_CYC cycles, then go to STRB.
- STRB: lasts EFUSE_STRB_CYC cycles, then go to HOLD. `i_efuse_dout` is sampled at the edge leaving STRB.
- HOLD: lasts EFUSE_HOLD_CYC cycles.
  - If `byte_idx` is EFUSE_BYTE_NUM-1, go to CHK.
  - Otherwise increment `byte_idx` and go to SETUP.
- The sampled byte is captured as follows:
  - It is written at the edge entering HOLD: `o_efuse_reg_wr_en`=1 for exactly one cycle, `o_efuse_reg_addr`=`byte_idx`, `o_efuse_reg_wdata`=sampled byte. The checksum byte is written too.
  - For bytes 0..N-2, the sum is accumulated mod 256 (8-bit wrap). The checksum byte is kept separately.
  - An OR-reduce blank flag is kept over all bytes.
- CHK: one cycle, then go to DONE.
  - `vld = (sum == checksum byte) & ~blank`.
  - An all-zero fuse array is invalid, even though 0 == 0.
- DONE:
  - `o_efuse_load_done`=1 and `o_efuse_vld` are updated at the edge entering DONE.
  - Stay in DONE while the request is high.
  - When the request falls, go to IDLE. `o_efuse_load_done` clears at that edge and `o_efuse_vld` is held.
- Outputs while the FSM is in a state:
  - csb is low in SETUP, STRB and HOLD; high in IDLE, CHK and DONE.
  - strobe is high only in STRB.
  - `o_efuse_addr`=`byte_idx` in SETUP, STRB and HOLD; 0 otherwise.
- Abort: if `i_efuse_load_req`=0 in SETUP, STRB, HOLD or CHK:
  - next state is IDLE;
  - csb goes high and strobe low at that edge;
  - no write pulse, done stays 0, `o_efuse_vld` stays 0.
- A new request after an abort or DONE restarts from byte 0. There is no partial resume.

## Timing
- All outputs are registered and change only on `i_clk`.
- Reset values:
  - state IDLE;
  - `o_efuse_csb`=1, `o_efuse_strobe`=0, `o_efuse_addr`=0;
  - `o_efuse_reg_wr_en`=0, `o_efuse_reg_addr`=0, `o_efuse_reg_wdata`=0;
  - `o_efuse_load_done`=0, `o_efuse_vld`=0.
- Edge 0 is the first edge that samples `i_efuse_load_req`=1 in IDLE; csb falls there.
- Per byte, P = EFUSE_SETUP_CYC+EFUSE_STRB_CYC+EFUSE_HOLD_CYC cycles. Byte k occupies edges P·k through P·k+P-1.
- `o_efuse_load_done` rises at edge P·N+1. With defaults (N=16, P=7) that is edge 113.
- The request falling while in DONE clears done at the next edge.
- Asynchronous reset mid-load returns the block to the reset values immediately.

## Structure
- Shared HV package (`hv_param.svh`) holds:
  - the efuse FSM state enum and its width constant;
  - the EFUSE_* defaults;
  - the efuse map constant: checksum byte index = EFUSE_BYTE_NUM-1.
- One sub-module, `hv_efuse_chk`, holds the accumulator, the checksum byte register, the blank flag and the vld compare. Its inputs are clear, byte strobe, data and a last-byte flag.
- The FSM and timing counters stay in the top module. Target size is about 200 lines of RTL.

## Test plan
- Default parameters, bytes 0..14 = 0x01..0x0F, byte 15 = 0x78 → 16 write pulses at addresses 0..15; done at edge 113; `o_efuse_vld`=1.
- Same data with byte 15 = 0x77 → done at edge 113; `o_efuse_vld`=0.
- All-zero array → done; `o_efuse_vld`=0 (blank).
- Drop the request during STRB of byte 5 → csb=1 and strobe=0 at the next edge; no further writes; done=0; vld=0. Re-request → full 113-cycle load from byte 0.
- Raise the request again after DONE with the request held, then dropped → done held until the request falls, clears one edge later; vld held through IDLE.
- Pulse `i_rst_n` low during HOLD of byte 3 → all outputs at reset values asynchronously; the next request restarts from byte 0.

Source files
------------

// File: rtl/hv_efuse_load_ctrl_pkg.sv
// Shared HV definitions for the efuse load path: FSM state encoding,
// timing defaults and the efuse byte map.
package hv_efuse_load_ctrl_pkg;

  localparam int EFUSE_ST_W = 3;

  typedef enum logic [EFUSE_ST_W-1:0] {
    EFUSE_ST_IDLE  = 3'd0,
    EFUSE_ST_SETUP = 3'd1,
    EFUSE_ST_STRB  = 3'd2,
    EFUSE_ST_HOLD  = 3'd3,
    EFUSE_ST_CHK   = 3'd4,
    EFUSE_ST_DONE  = 3'd5
  } efuse_st_e;

  localparam int EFUSE_BYTE_NUM_DEF  = 16;
  localparam int EFUSE_ADDR_W_DEF    = 4;
  localparam int EFUSE_SETUP_CYC_DEF = 2;
  localparam int EFUSE_STRB_CYC_DEF  = 4;
  localparam int EFUSE_HOLD_CYC_DEF  = 1;

  // The checksum lives in the last byte of the array.
  function automatic int efuse_chk_idx(input int byte_num);
    return byte_num - 1;
  endfunction

  function automatic int efuse_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hv_efuse_chk.sv
// Efuse checksum engine: 8-bit wrapping sum of the data bytes, captured
// checksum byte and a not-blank flag; vld is the combined verdict.
module hv_efuse_chk
  import hv_efuse_load_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       clr,
  input  logic       byte_stb,
  input  logic [7:0] data,
  input  logic       last,
  output logic       vld
);

  logic [7:0] sum_r;
  logic [7:0] chk_byte_r;
  logic       nonblank_r;

  // Accumulate data bytes; the last byte is the stored checksum, not summed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_r      <= 8'h00;
      chk_byte_r <= 8'h00;
      nonblank_r <= 1'b0;
    end else if (clr) begin
      sum_r      <= 8'h00;
      chk_byte_r <= 8'h00;
      nonblank_r <= 1'b0;
    end else if (byte_stb) begin
      nonblank_r <= nonblank_r | (|data);
      if (last) begin
        chk_byte_r <= data;
      end else begin
        sum_r <= sum_r + data;
      end
    end else begin
      sum_r      <= sum_r;
      chk_byte_r <= chk_byte_r;
      nonblank_r <= nonblank_r;
    end
  end

  // An all-zero array would match trivially, so blank is always invalid.
  assign vld = (sum_r == chk_byte_r) & nonblank_r;

endmodule

// File: rtl/hv_efuse_load_ctrl.sv
// Efuse load controller: sequences the fuse macro byte by byte, mirrors each
// byte into the register bank and reports done/valid to the HV control FSM.
module hv_efuse_load_ctrl
  import hv_efuse_load_ctrl_pkg::*;
#(
  parameter int EFUSE_BYTE_NUM  = EFUSE_BYTE_NUM_DEF,
  parameter int EFUSE_ADDR_W    = EFUSE_ADDR_W_DEF,
  parameter int EFUSE_SETUP_CYC = EFUSE_SETUP_CYC_DEF,
  parameter int EFUSE_STRB_CYC  = EFUSE_STRB_CYC_DEF,
  parameter int EFUSE_HOLD_CYC  = EFUSE_HOLD_CYC_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_efuse_load_req,
  output logic                    o_efuse_csb,
  output logic                    o_efuse_strobe,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
  input  logic [7:0]              i_efuse_dout,
  output logic                    o_efuse_reg_wr_en,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_reg_addr,
  output logic [7:0]              o_efuse_reg_wdata,
  output logic                    o_efuse_load_done,
  output logic                    o_efuse_vld
);

  localparam int CNT_MAX = efuse_max3(EFUSE_SETUP_CYC, EFUSE_STRB_CYC, EFUSE_HOLD_CYC);
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(EFUSE_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STRB_LAST  = CNT_W'(EFUSE_STRB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(EFUSE_HOLD_CYC - 1);
  localparam logic [EFUSE_ADDR_W-1:0] LAST_IDX = EFUSE_ADDR_W'(efuse_chk_idx(EFUSE_BYTE_NUM));

  efuse_st_e               state_r;
  logic [CNT_W-1:0]        cyc_cnt_r;
  logic [EFUSE_ADDR_W-1:0] byte_idx_r;
  logic                    chk_clr_s;
  logic                    byte_stb_s;
  logic                    last_byte_s;
  logic                    chk_vld_s;

  assign last_byte_s = (byte_idx_r == LAST_IDX);
  assign chk_clr_s   = (state_r == EFUSE_ST_IDLE) & i_efuse_load_req;
  // Same condition that produces the register write pulse.
  assign byte_stb_s  = (state_r == EFUSE_ST_STRB) & i_efuse_load_req & (cyc_cnt_r == STRB_LAST);

  hv_efuse_chk u_chk (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .clr      (chk_clr_s),
    .byte_stb (byte_stb_s),
    .data     (i_efuse_dout),
    .last     (last_byte_s),
    .vld      (chk_vld_s)
  );

  // Load sequencer; every macro and register-bank output is set for the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r           <= EFUSE_ST_IDLE;
      cyc_cnt_r         <= {CNT_W{1'b0}};
      byte_idx_r        <= {EFUSE_ADDR_W{1'b0}};
      o_efuse_csb       <= 1'b1;
      o_efuse_strobe    <= 1'b0;
      o_efuse_addr      <= {EFUSE_ADDR_W{1'b0}};
      o_efuse_reg_wr_en <= 1'b0;
      o_efuse_reg_addr  <= {EFUSE_ADDR_W{1'b0}};
      o_efuse_reg_wdata <= 8'h00;
      o_efuse_load_done <= 1'b0;
      o_efuse_vld       <= 1'b0;
    end else begin
      o_efuse_reg_wr_en <= 1'b0;
      if (!i_efuse_load_req && state_r != EFUSE_ST_IDLE && state_r != EFUSE_ST_DONE) begin
        state_r        <= EFUSE_ST_IDLE;
        cyc_cnt_r      <= {CNT_W{1'b0}};
        o_efuse_csb    <= 1'b1;
        o_efuse_strobe <= 1'b0;
        o_efuse_addr   <= {EFUSE_ADDR_W{1'b0}};
      end else begin
        case (state_r)
          EFUSE_ST_IDLE: begin
            if (i_efuse_load_req) begin
              state_r        <= EFUSE_ST_SETUP;
              cyc_cnt_r      <= {CNT_W{1'b0}};
              byte_idx_r     <= {EFUSE_ADDR_W{1'b0}};
              o_efuse_csb    <= 1'b0;
              o_efuse_strobe <= 1'b0;
              o_efuse_addr   <= {EFUSE_ADDR_W{1'b0}};
              o_efuse_vld    <= 1'b0;
            end else begin
              state_r <= EFUSE_ST_IDLE;
            end
          end
          EFUSE_ST_SETUP: begin
            if (cyc_cnt_r == SETUP_LAST) begin
              state_r        <= EFUSE_ST_STRB;
              cyc_cnt_r      <= {CNT_W{1'b0}};
              o_efuse_strobe <= 1'b1;
            end else begin
              cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
            end
          end
          EFUSE_ST_STRB: begin
            if (cyc_cnt_r == STRB_LAST) begin
              state_r           <= EFUSE_ST_HOLD;
              cyc_cnt_r         <= {CNT_W{1'b0}};
              o_efuse_strobe    <= 1'b0;
              o_efuse_reg_wr_en <= 1'b1;
              o_efuse_reg_addr  <= byte_idx_r;
              o_efuse_reg_wdata <= i_efuse_dout;
            end else begin
              cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
            end
          end
          EFUSE_ST_HOLD: begin
            if (cyc_cnt_r != HOLD_LAST) begin
              cyc_cnt_r <= cyc_cnt_r + CNT_W'(1);
            end else if (last_byte_s) begin
              state_r      <= EFUSE_ST_CHK;
              cyc_cnt_r    <= {CNT_W{1'b0}};
              o_efuse_csb  <= 1'b1;
              o_efuse_addr <= {EFUSE_ADDR_W{1'b0}};
            end else begin
              state_r      <= EFUSE_ST_SETUP;
              cyc_cnt_r    <= {CNT_W{1'b0}};
              byte_idx_r   <= byte_idx_r + EFUSE_ADDR_W'(1);
              o_efuse_addr <= byte_idx_r + EFUSE_ADDR_W'(1);
            end
          end
          EFUSE_ST_CHK: begin
            state_r           <= EFUSE_ST_DONE;
            o_efuse_load_done <= 1'b1;
            o_efuse_vld       <= chk_vld_s;
          end
          EFUSE_ST_DONE: begin
            if (!i_efuse_load_req) begin
              state_r           <= EFUSE_ST_IDLE;
              o_efuse_load_done <= 1'b0;
            end else begin
              state_r <= EFUSE_ST_DONE;
            end
          end
          default: begin
            state_r           <= EFUSE_ST_IDLE;
            cyc_cnt_r         <= {CNT_W{1'b0}};
            o_efuse_csb       <= 1'b1;
            o_efuse_strobe    <= 1'b0;
            o_efuse_addr      <= {EFUSE_ADDR_W{1'b0}};
            o_efuse_load_done <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hv_efuse_load_ctrl.sv
// Directed bench for hv_efuse_load_ctrl: table of fuse images with
// hand-computed verdicts, plus abort, done-hold and async-reset sequences.
module tb_hv_efuse_load_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       csb;
  logic       strobe;
  logic [3:0] addr;
  logic [7:0] dout;
  logic       wr_en;
  logic [3:0] reg_addr;
  logic [7:0] wdata;
  logic       done;
  logic       vld;

  logic [7:0] mem [16];
  logic [3:0] seq_addr [1024];
  logic [7:0] seq_data [1024];
  int         wr_cnt = 0;
  int         tests  = 0;
  int         fails  = 0;

  typedef struct {
    logic [1:0] mode;     // 0: bytes i+1, 1: zero, 2: 0xFF
    logic [7:0] chk;
    logic       exp_vld;
  } vec_t;

  vec_t vecs [5];

  hv_efuse_load_ctrl dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_efuse_load_req  (req),
    .o_efuse_csb       (csb),
    .o_efuse_strobe    (strobe),
    .o_efuse_addr      (addr),
    .i_efuse_dout      (dout),
    .o_efuse_reg_wr_en (wr_en),
    .o_efuse_reg_addr  (reg_addr),
    .o_efuse_reg_wdata (wdata),
    .o_efuse_load_done (done),
    .o_efuse_vld       (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fuse macro model: data only while the strobe is high.
  assign dout = strobe ? mem[addr] : 8'h00;

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (wr_cnt < 1024) begin
        seq_addr[wr_cnt] = reg_addr;
        seq_data[wr_cnt] = wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [1:0] mode, input logic [7:0] chk);
    for (int i = 0; i < 15; i++) begin
      case (mode)
        2'd0:    mem[i] = 8'(i + 1);
        2'd1:    mem[i] = 8'h00;
        default: mem[i] = 8'hFF;
      endcase
    end
    mem[15] = chk;
  endtask

  // Raise the request and return the edge index at which done rises (-1 if never).
  task automatic run_load(output int done_edge);
    done_edge = -1;
    @(negedge clk);
    req = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (n == 0) check("csb_edge0", {31'd0, csb}, 32'd0);
      if (done) begin
        done_edge = n;
        break;
      end
    end
  endtask

  task automatic check_writes(input int w0, input int exp_n);
    int errs;
    errs = 0;
    check("wr_count", wr_cnt - w0, exp_n);
    for (int k = 0; k < exp_n && (w0 + k) < 1024; k++) begin
      if (seq_addr[w0 + k] !== 4'(k) || seq_data[w0 + k] !== mem[k]) errs++;
    end
    check("wr_addr_data", errs, 0);
  endtask

  task automatic full_load(input logic exp_vld);
    int w0;
    int de;
    w0 = wr_cnt;
    run_load(de);
    check("done_edge", de, 113);
    check("vld", {31'd0, vld}, {31'd0, exp_vld});
    @(negedge clk);
    check_writes(w0, 16);
  endtask

  initial begin
    int w0;
    vecs[0] = '{2'd0, 8'h78, 1'b1};
    vecs[1] = '{2'd0, 8'h77, 1'b0};
    vecs[2] = '{2'd1, 8'h00, 1'b0};
    vecs[3] = '{2'd1, 8'h01, 1'b0};
    vecs[4] = '{2'd2, 8'hF1, 1'b1};
    fill(2'd0, 8'h78);
    rst_n = 1'b0;
    req   = 1'b0;
    #12;
    check("rst_csb",    {31'd0, csb},    32'd1);
    check("rst_strobe", {31'd0, strobe}, 32'd0);
    check("rst_addr",   {28'd0, addr},   32'd0);
    check("rst_wr",     {31'd0, wr_en},  32'd0);
    check("rst_done",   {31'd0, done},   32'd0);
    check("rst_vld",    {31'd0, vld},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of images; each ends with request held, then dropped.
    for (int v = 0; v < 5; v++) begin
      fill(vecs[v].mode, vecs[v].chk);
      full_load(vecs[v].exp_vld);
      repeat (4) @(posedge clk);
      #1;
      check("done_held", {31'd0, done}, 32'd1);
      @(negedge clk);
      req = 1'b0;
      #1;
      check("done_before_edge", {31'd0, done}, 32'd1);
      @(posedge clk);
      #1;
      check("done_cleared", {31'd0, done}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("vld_held_idle", {31'd0, vld}, {31'd0, vecs[v].exp_vld});
    end

    // Abort during STRB of byte 5 (edge 38), then a full reload.
    fill(2'd0, 8'h78);
    w0 = wr_cnt;
    @(negedge clk);
    req = 1'b1;
    repeat (39) @(posedge clk);
    #1;
    check("abort_strobe_on", {31'd0, strobe}, 32'd1);
    check("abort_addr5",     {28'd0, addr},   32'd5);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    check("abort_csb",    {31'd0, csb},    32'd1);
    check("abort_strobe", {31'd0, strobe}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_writes", wr_cnt - w0, 5);
    check("abort_done",   {31'd0, done}, 32'd0);
    check("abort_vld",    {31'd0, vld},  32'd0);
    full_load(1'b1);
    @(negedge clk);
    req = 1'b0;
    repeat (3) @(negedge clk);

    // Async reset during HOLD of byte 3 (entered at edge 27).
    @(negedge clk);
    req = 1'b1;
    repeat (28) @(posedge clk);
    #1;
    check("hold3_wr",   {31'd0, wr_en},   32'd1);
    check("hold3_addr", {28'd0, reg_addr}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("arst_csb",   {31'd0, csb},      32'd1);
    check("arst_addr",  {28'd0, addr},     32'd0);
    check("arst_wr",    {31'd0, wr_en},    32'd0);
    check("arst_raddr", {28'd0, reg_addr}, 32'd0);
    check("arst_wdata", {24'd0, wdata},    32'd0);
    check("arst_vld",   {31'd0, vld},      32'd0);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    full_load(1'b1);
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
